// File: rtl/sc_mul16_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sc_mul16_fsm
// Description : Sequential stochastic-computing unsigned multiplier.
//               Each operand is quantized to its top STREAM_BITS bits. Then
//               2^STREAM_BITS stream bits are generated per operand:
//                 A: unary comparator        sa = (aq > i)
//                 B: bit-reversed comparator sb = (bq > rev(i))
//               The AND-coincidences are counted. The result is the count
//               scaled back to the full 2*DATA_WIDTH product range.
//
//               Optional build macro SC_MUL_ROUND_EN: the operands are
//               quantized by round-half-up with saturation, not by truncation.
//
// Ports       : clk          in   clock, rising edge
//               rst_n        in   asynchronous active-low reset
//               start        in   request, sampled only in IDLE
//               io_inputs_a  in   operand A (unsigned)
//               io_inputs_b  in   operand B (unsigned)
//               busy         out  high while the FSM is not IDLE
//               done         out  one-cycle completion pulse (registered)
//               mul_result   out  approximate A*B; held until next completion
//
// Revision    : 1.0 - initial release
// ============================================================================
module sc_mul16_fsm #(
  parameter int DATA_WIDTH  = 16,
  parameter int STREAM_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   io_inputs_a,
  input  logic [DATA_WIDTH-1:0]   io_inputs_b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] mul_result
);

  localparam int RES_SHIFT = 2*DATA_WIDTH - STREAM_BITS;
  localparam logic [STREAM_BITS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [STREAM_BITS-1:0]  idx_q, idx_d;
  logic [STREAM_BITS:0]    count_q, count_d;
  logic [STREAM_BITS-1:0]  aq_q, aq_d;
  logic [STREAM_BITS-1:0]  bq_q, bq_d;
  logic [2*DATA_WIDTH-1:0] mul_result_q, mul_result_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [STREAM_BITS-1:0]  aq_in, bq_in;
  logic [STREAM_BITS-1:0]  idx_rev;
  logic                    hit;
  logic [STREAM_BITS:0]    count_next;

  // --------------------------------------------------------------------------
  // Operand quantization
  // --------------------------------------------------------------------------
`ifdef SC_MUL_ROUND_EN
  // Round half up on the first discarded bit. Saturate at all-ones so that
  // 0xFF80 and larger values do not wrap to zero.
  logic [STREAM_BITS:0] a_sum, b_sum;
  logic                 unused_lsbs;

  assign a_sum = {1'b0, io_inputs_a[DATA_WIDTH-1 -: STREAM_BITS]}
               + {{STREAM_BITS{1'b0}}, io_inputs_a[DATA_WIDTH-STREAM_BITS-1]};
  assign b_sum = {1'b0, io_inputs_b[DATA_WIDTH-1 -: STREAM_BITS]}
               + {{STREAM_BITS{1'b0}}, io_inputs_b[DATA_WIDTH-STREAM_BITS-1]};
  assign aq_in = a_sum[STREAM_BITS] ? {STREAM_BITS{1'b1}} : a_sum[STREAM_BITS-1:0];
  assign bq_in = b_sum[STREAM_BITS] ? {STREAM_BITS{1'b1}} : b_sum[STREAM_BITS-1:0];
  assign unused_lsbs = ^{io_inputs_a[DATA_WIDTH-STREAM_BITS-2:0],
                         io_inputs_b[DATA_WIDTH-STREAM_BITS-2:0]};
`else
  logic unused_lsbs;

  assign aq_in = io_inputs_a[DATA_WIDTH-1 -: STREAM_BITS];
  assign bq_in = io_inputs_b[DATA_WIDTH-1 -: STREAM_BITS];
  assign unused_lsbs = ^{io_inputs_a[DATA_WIDTH-STREAM_BITS-1:0],
                         io_inputs_b[DATA_WIDTH-STREAM_BITS-1:0]};
`endif

  // --------------------------------------------------------------------------
  // Bit-reversed index: the van der Corput sequence decorrelates stream B
  // from the unary stream A.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STREAM_BITS; k++) begin : g_rev
    assign idx_rev[k] = idx_q[STREAM_BITS-1-k];
  end

  assign hit        = (aq_q > idx_q) & (bq_q > idx_rev);
  assign count_next = count_q + {{STREAM_BITS{1'b0}}, hit};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    aq_d         = aq_q;
    bq_d         = bq_q;
    mul_result_d = mul_result_q;
    done_d       = 1'b0;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          aq_d    = aq_in;
          bq_d    = bq_in;
          idx_d   = '0;
          count_d = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        count_d = count_next;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          // The count never exceeds 2^STREAM_BITS-1, so its low bits carry
          // the full value.
          mul_result_d = {count_next[STREAM_BITS-1:0], {RES_SHIFT{1'b0}}};
          done_d       = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      aq_q         <= '0;
      bq_q         <= '0;
      mul_result_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      aq_q         <= aq_d;
      bq_q         <= bq_d;
      mul_result_q <= mul_result_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mul_result = mul_result_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_mul16_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_mul16_fsm
// Description : Self-checking bench for sc_mul16_fsm. The bench applies a
//               table of operand pairs with known products, a few randomized
//               pairs, an asynchronous reset that aborts a running operation,
//               a start/operand disturbance during RUN, and start held high
//               for 600 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_mul16_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  wire         busy;
  wire         done;
  wire  [31:0] mul_result;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  sc_mul16_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .io_inputs_a (a),
    .io_inputs_b (b),
    .busy        (busy),
    .done        (done),
    .mul_result  (mul_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] exp_trunc;
    logic [31:0] exp_round;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: quantize the operands, then walk the streams.
  function automatic logic [7:0] quant(input logic [15:0] x);
    logic [8:0] s;
`ifdef SC_MUL_ROUND_EN
    s = {1'b0, x[15:8]} + {8'd0, x[7]};
    return s[8] ? 8'hFF : s[7:0];
`else
    s = {1'b0, x[15:8]};
    return s[7:0];
`endif
  endfunction

  function automatic logic [31:0] model_mul(input logic [15:0] va, input logic [15:0] vb);
    int cnt;
    logic [7:0] aq, bq, iv, rv;
    aq = quant(va);
    bq = quant(vb);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      iv = i[7:0];
      for (int k = 0; k < 8; k++) rv[k] = iv[7-k];
      if ((aq > iv) && (bq > rv)) cnt++;
    end
    return {cnt[7:0], 24'h0};
  endfunction

  // One operation: start at a negedge, check latency and result. If disturb
  // is set, the operands are changed and start is pulsed while RUN is active.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        input logic [31:0] exp, input bit disturb, input string name);
    int n;
    logic [31:0] e;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (disturb && n == 10) begin
        a = ~va;
        b = ~vb;
        start = 1'b1;
      end
      if (disturb && n == 11) start = 1'b0;
    end
    check({name, " latency"}, 32'(n), 32'd256);
    if (done) begin
      e = sb_q.pop_front();
      check({name, " result"}, mul_result, e);
    end else begin
      sb_q.delete();
    end
    @(negedge clk);
    check({name, " done single"}, 32'(done), 32'd0);
    check({name, " busy idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses, done_cycles, busy_low, n;
    logic prev_done;
    logic [15:0] ra, rb;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFF000000, 32'hFF000000};
    vecs[1] = '{16'h8000, 16'h8000, 32'h40000000, 32'h40000000};
    vecs[2] = '{16'h80AB, 16'hFF12, 32'h80000000, 32'h81000000};
    vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000, 32'h00000000};
    vecs[4] = '{16'h4000, 16'h4000, 32'h10000000, 32'h10000000};
    vecs[5] = '{16'h0100, 16'hFFFF, 32'h01000000, 32'h01000000};
    vecs[6] = '{16'hFFFF, 16'h0100, 32'h01000000, 32'h01000000};
    vecs[7] = '{16'h7F80, 16'hFFFF, 32'h7F000000, 32'h80000000};

    // Reset state
    #2;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", mul_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
`ifdef SC_MUL_ROUND_EN
      run_op(vecs[v].va, vecs[v].vb, vecs[v].exp_round, 1'b0, $sformatf("vec%0d", v));
`else
      run_op(vecs[v].va, vecs[v].vb, vecs[v].exp_trunc, 1'b0, $sformatf("vec%0d", v));
`endif
    end

    // Randomized operands against the model
    for (int r = 0; r < 3; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, model_mul(ra, rb), 1'b0, $sformatf("rand%0d", r));
    end

    // Operands changed and start pulsed during RUN: the latched values are used.
    run_op(16'h8000, 16'h8000, 32'h40000000, 1'b1, "disturb");

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", mul_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hFFFF, 16'hFFFF, 32'hFF000000, 1'b0, "post-reset");

    // start held high for 600 cycles
    @(negedge clk);
    a = 16'h8000;
    b = 16'h8000;
    start = 1'b1;
    pulses = 0;
    done_cycles = 0;
    busy_low = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) begin
        done_cycles++;
        if (!prev_done) pulses++;
        check("hold result", mul_result, 32'h40000000);
      end
      if (pulses == 1 && !done && !busy) busy_low++;
      prev_done = done;
    end
    start = 1'b0;
    check("hold pulses", 32'(pulses), 32'd2);
    check("hold done cycles", 32'(done_cycles), 32'd2);
    check("hold busy gap", 32'(busy_low > 0), 32'd1);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("hold drain", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
